// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and sizing helper
// for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: per-cycle shift-add multiply / restoring divide step.
// acc holds {upper, lower} for multiply and {remainder, quotient} for divide.
module muldiv_iter_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   init,
   input  logic [WIDTH-1:0]   dvs,
   output logic [2*WIDTH-1:0] acc
);

   logic [WIDTH-1:0]   up;
   logic [WIDTH-1:0]   low;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     sh;
   logic [WIDTH-1:0]   diff;
   logic               ge;
   logic [WIDTH-1:0]   rem;
   logic [2*WIDTH-1:0] mul_nxt;
   logic [2*WIDTH-1:0] div_nxt;

   assign up  = acc[2*WIDTH-1:WIDTH];
   assign low = acc[WIDTH-1:0];

   always_comb begin
      sum     = {1'b0, up} + (low[0] ? {1'b0, dvs} : '0);
      mul_nxt = {sum, low[WIDTH-1:1]};
      sh      = {up, low[WIDTH-1]};
      ge      = sh >= {1'b0, dvs};
      // when ge holds the true difference is below dvs, so WIDTH bits suffice
      diff    = sh[WIDTH-1:0] - dvs;
      rem     = ge ? diff : sh[WIDTH-1:0];
      div_nxt = {rem, low[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (load) begin
         acc <= {{WIDTH{1'b0}}, init};
      end else if (step) begin
         acc <= is_div ? div_nxt : mul_nxt;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle mult/div owning HI/LO, with stall and
// flush handling for the five-stage pipeline.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit FAST_MUL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             dz
);

   localparam int CW = clog2(WIDTH);

   state_t state;
   state_t nxt;

   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   ma;
   logic [WIDTH-1:0]   mb;
   logic [WIDTH-1:0]   a_q;
   logic               div_q;
   logic               neg_q;
   logic               neg_r;
   logic               sgn;
   logic               is_div;
   logic               go;
   logic               load;
   logic               step;
   logic               fin;
   logic               dz_c;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] fprod;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   q_s;
   logic [WIDTH-1:0]   r_s;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign sgn    = (op == OP_MULT) | (op == OP_DIV);
   assign is_div = (op == OP_DIV) | (op == OP_DIVU);
   assign a_mag  = (sgn & a[WIDTH-1]) ? -a : a;
   assign b_mag  = (sgn & b[WIDTH-1]) ? -b : b;
   assign go     = (state == S_IDLE) & start & ~abort;

   assign busy  = state != S_IDLE;
   assign stall = busy & (start | rd_req | wr_hi | wr_lo);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt  = state;
      load = 1'b0;
      step = 1'b0;
      fin  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (go) begin
               if (FAST_MUL && !is_div) begin
                  nxt = S_FIX;
               end else begin
                  nxt  = S_RUN;
                  load = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               nxt = S_IDLE;
            end else begin
               step = 1'b1;
               if (cnt == '0) nxt = S_FIX;
            end
         end
         S_FIX: begin
            nxt = S_IDLE;
            fin = ~abort;
         end
         default: nxt = S_IDLE;
      endcase
   end

   muldiv_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .is_div (div_q),
      .init   (a_mag),
      .dvs    (mb),
      .acc    (acc)
   );

   assign fprod = {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
   assign dz_c  = div_q & (mb == '0);

   always_comb begin
      prod   = FAST_MUL ? fprod : acc;
      prod_s = neg_q ? -prod : prod;
      q_s    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      r_s    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
      unique case (1'b1)
         dz_c: begin
            res_hi = a_q;
            res_lo = '1;
         end
         div_q & ~dz_c: begin
            res_hi = r_s;
            res_lo = q_s;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ma    <= '0;
         mb    <= '0;
         a_q   <= '0;
         div_q <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         cnt   <= '0;
      end else begin
         if (go) begin
            ma    <= a_mag;
            mb    <= b_mag;
            a_q   <= a;
            div_q <= is_div;
            neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= sgn & a[WIDTH-1];
         end
         if (load)      cnt <= CW'(WIDTH - 1);
         else if (step) cnt <= cnt - 1'b1;
      end
   end

   // mthi/mtlo only land while idle; a finishing result owns the edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
         dz   <= 1'b0;
      end else begin
         done <= fin;
         dz   <= fin & dz_c;
         if (fin) begin
            hi <= res_hi;
            lo <= res_lo;
         end else if (state == S_IDLE) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
         end
      end
   end

endmodule
